// File: rtl/hci_mem_responder.sv
// hci_mem_responder: single-cycle TCDM memory endpoint with optional LFSR grant throttling
module hci_mem_responder #(
  parameter int          DW        = 32,
  parameter int          AW        = 32,
  parameter int          IW        = 8,
  parameter int          UW        = 1,
  parameter int          NB_WORDS  = 1024,
  parameter int          STALL_EN  = 0,
  parameter int          MAX_STALL = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              tcdm_req_i,
  output logic              tcdm_gnt_o,
  input  logic [AW-1:0]     tcdm_add_i,
  input  logic              tcdm_we_n_i,
  input  logic [DW-1:0]     tcdm_data_i,
  input  logic [DW/8-1:0]   tcdm_be_i,
  input  logic [IW-1:0]     tcdm_id_i,
  input  logic [UW-1:0]     tcdm_user_i,
  output logic [DW-1:0]     tcdm_r_data_o,
  output logic [IW-1:0]     tcdm_r_id_o,
  output logic [UW-1:0]     tcdm_r_user_o,
  output logic              tcdm_r_valid_o
);
  localparam int BW = DW / 8;
  localparam int OW = $clog2(BW);
  localparam int XW = $clog2(NB_WORDS);
  logic [DW-1:0] mem [NB_WORDS];
  logic [XW-1:0] idx;
  logic [15:0]   lfsr;
  logic [3:0]    stall_cnt;
  logic          stall;
  logic          gnt;
  logic          unused_add;
  // byte offset and bits above the index are dropped, so the space aliases
  assign idx        = tcdm_add_i[OW +: XW];
  assign unused_add = ^{tcdm_add_i[AW-1:OW+XW], tcdm_add_i[OW-1:0]};
  assign stall      = (STALL_EN != 0) && (lfsr[1:0] == 2'b00) && (stall_cnt != 4'(MAX_STALL));
  assign gnt        = tcdm_req_i & ~clear_i & ~stall;
  assign tcdm_gnt_o = gnt;
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      lfsr      <= LFSR_SEED;
      stall_cnt <= '0;
    end else begin
      if (tcdm_req_i) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      stall_cnt <= (tcdm_req_i & ~gnt) ? stall_cnt + 4'd1 : 4'd0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (gnt && !tcdm_we_n_i)
      for (int i = 0; i < BW; i++)
        if (tcdm_be_i[i]) mem[idx][8*i +: 8] <= tcdm_data_i[8*i +: 8];
  end
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      tcdm_r_data_o  <= '0;
      tcdm_r_id_o    <= '0;
      tcdm_r_user_o  <= '0;
      tcdm_r_valid_o <= 1'b0;
    end else begin
      tcdm_r_valid_o <= gnt;
      if (gnt) begin
        tcdm_r_id_o   <= tcdm_id_i;
        tcdm_r_user_o <= tcdm_user_i;
        if (tcdm_we_n_i) tcdm_r_data_o <= mem[idx];
      end
    end
  end
endmodule
